// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand hazard controller for a 5-stage MIPS pipeline.
// It drives the PC and IF/ID freezes, the ID/EX bubble and the IF/ID flush, and counts stall and flush cycles.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          BRANCH_IN_ID = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_ID,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             branch_taken_ID,
  input  logic             jump_ID,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic {RUN, STALL2} state_t;

  state_t     state, state_nxt;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       use_rs, use_rt, is_br;
  logic       ex_hit, mem_hit;
  logic       need_any, need_two;
  logic       unused_imm;

  assign op         = inst_ID[31:26];
  assign rs         = inst_ID[25:21];
  assign rt         = inst_ID[20:16];
  assign unused_imm = ^inst_ID[15:0];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (op)
      6'h00, 6'h2B, 6'h04, 6'h05: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D: use_rs = 1'b1;
      default: ;
    endcase
  end

  assign is_br = BRANCH_IN_ID && ((op == 6'h04) || (op == 6'h05));

  // Register $0 is hard-wired, so it never creates a dependence.
  assign ex_hit  = (use_rs && (rs != '0) && (rs == ex_rd)) ||
                   (use_rt && (rt != '0) && (rt == ex_rd));
  assign mem_hit = (use_rs && (rs != '0) && (rs == mem_rd)) ||
                   (use_rt && (rt != '0) && (rt == mem_rd));

  assign need_two = ex_mem_read && ex_hit && is_br;
  assign need_any = (ex_mem_read && ex_hit) ||
                    (is_br && ex_reg_write && ex_hit) ||
                    (is_br && mem_mem_read && mem_hit);

  always_comb begin
    state_nxt   = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (need_any) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = need_two ? STALL2 : RUN;
          end else begin
            ifid_flush = branch_taken_ID || jump_ID;
          end
        end
        STALL2: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && (flush_cycles != '1))
        flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end

  assign stalled = (state == STALL2);

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Decodes the instruction in ID against the destination/control state of EX and MEM, and decides when to do each of the following:
  - freeze PC and IF/ID;
  - inject a bubble into ID/EX by zeroing ctrl_ID at the ID/EX register input;
  - flush IF/ID after a taken branch or jump.
- Branches resolve in ID. EX/MEM→EX forwarding exists; MEM→ID forwarding exists for branch compares.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16: width of the stall_cycles and flush_cycles counters.
- BRANCH_IN_ID, 1:
  - 1: branch operands are needed in ID, so the extra branch stalls apply.
  - 0: branches are treated as ordinary EX-stage consumers.

Ports:
- clk  in  1  pipeline clock, posedge
- rst  in  1  synchronous, active-high reset
- inst_ID  in  32  instruction currently in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes the register file
- ex_rd  in  5  destination register of the instruction in EX
- mem_mem_read  in  1  instruction in MEM is a load
- mem_rd  in  5  destination register of the instruction in MEM
- branch_taken_ID  in  1  branch in ID resolved taken
- jump_ID  in  1  j/jal in ID
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_bubble  out  1  forces ctrl into ID/EX to 0
- ifid_flush  out  1  zeroes IF/ID on the next edge
- stalled  out  1  state == STALL2
- stall_cycles  out  CNT_W  count of cycles with pc_write=0 (excluding reset)
- flush_cycles  out  CNT_W  count of cycles with ifid_flush=1 (excluding reset)

Behaviour:
Decode (on inst_ID):
- op = [31:26], rs = [25:21], rt = [20:16].
- rs is used by: op 0x00, 0x23, 0x2B, 0x04, 0x05, 0x08, 0x0A, 0x0C, 0x0D.
- rt is used by: op 0x00, 0x2B, 0x04, 0x05.
- is_br: op is 0x04 or 0x05, and BRANCH_IN_ID = 1.
- A source equal to $0 never matches.
- Opcodes not listed above use no sources.

Stall need, n. The first matching rule wins:
- n=2: ex_mem_read, ex_rd matches a used source, and is_br.
- n=1: ex_mem_read and ex_rd matches (not is_br).
- n=1: is_br, ex_reg_write, not ex_mem_read, and ex_rd matches.
- n=1: is_br, mem_mem_read, and mem_rd matches.
- n=0 otherwise.

FSM, states RUN and STALL2, registered:
- RUN:
  - If n>0: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Next state is STALL2 if n=2, else RUN. The condition is re-evaluated naturally on the next cycle.
- RUN, n=0:
  - pc_write=1, ifid_write=1, idex_bubble=0.
  - ifid_flush = branch_taken_ID | jump_ID.
- STALL2:
  - Same stall outputs as RUN with n>0.
  - Inputs are ignored; the next state is unconditionally RUN.

Priority and output timing:
- Stall beats flush: branch_taken_ID or jump_ID during any stall cycle gives ifid_flush=0.
- All outputs except the counters and stalled are combinational from state and inputs, with 0-cycle latency.

Counters:
- Increment on the clock edge after each qualifying cycle.
- Saturate at all-ones (no wrap).

Reset:
- rst is sampled at posedge. While rst=1 the outputs are pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1.
- On the next edge: state=RUN, both counters=0, stalled=0.
- Reset asserted in STALL2 aborts the remaining stall.

Test Plan:
1. ex_mem_read=1, ex_rd=2, inst_ID=0x00441820 (add $3,$2,$4) → that cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle, with ex_mem_read=0, outputs are normal; stall_cycles=1.
2. ex_mem_read=1, ex_rd=2, inst_ID=0x10400003 (beq $2,$0), branch_taken_ID=1 → two stall cycles, stalled=1 in the second, ifid_flush=0 in both. Third cycle (EX holds a bubble, MEM has no load to $2) → ifid_flush=1; stall_cycles=2, flush_cycles=1.
3. ex_reg_write=1, ex_mem_read=0, ex_rd=5, inst_ID=0x10A60002 (beq $5,$6) → 1 stall cycle. Repeat with BRANCH_IN_ID=0 → no stall.
4. ex_mem_read=1, ex_rd=0, inst_ID=0x00001020 (add $2,$0,$0) → no stall.
   Separately: mem_mem_read=1, mem_rd=6, with beq $5,$6 → 1 stall.
5. jump_ID=1 with no hazard → ifid_flush=1 for exactly that cycle.
   Drive 2^CNT_W+3 flush cycles (use CNT_W=4) → flush_cycles holds at 15.
6. Enter STALL2 (scenario 2), then assert rst during STALL2 → that cycle idex_bubble=1 and ifid_flush=1. After release: state RUN, stalled=0, counters 0, no residual stall.
